stark_fetch_pcgen: RTL and testbench
====================================

Name: stark_fetch_pcgen

Overview:
- Fetch-address generator: the producer side of the fetch stage's PC/icache interface.
- Drives the fetch PC (with branch numbers), the reset-settle counter and stomp info into the fetch stage.
- Sequences sequential fetch, icache-miss hold, predicted-taken redirects and mispredict recovery.
- Sits between the branch predictor/commit logic and the fetch pipeline register stage.

Parameters:
FETCH_INC, 20, byte increment of PC per advanced fetch group (five 4-byte slots)
BNO_W, 6, width of branch number fields bno_t/bno_f
MISS_TMO, 255, icache-miss wait cycles before asserting miss_tmo

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
en  in  1  fetch pipeline advance enable
ihit  in  1  icache hit for the current pc_o
branch_miss  in  1  mispredict from backend; one-cycle pulse
misspc  in  pc_address_ex_t  corrected target for branch_miss
bp_taken  in  1  predicted-taken redirect from predecoder; one-cycle pulse
bp_tgt  in  pc_address_ex_t  predicted target (pc field only used)
pc_o  out  pc_address_ex_t  current fetch PC to fetch stage
rstcnt  out  3  post-reset settle counter
stomp_fet  out  1  stomp younger fetch groups
stomp_bno  out  BNO_W  branch number that survives the stomp
miss_tmo  out  1  sticky miss-timeout flag

Behaviour:
- Reset (rst low, async): pc_o.pc=RSTPC, bno_t=bno_f=1; rstcnt=0; stomp_fet=0; stomp_bno=0; miss_tmo=0; state=RESET; miss counter=0; pending-redirect register cleared.
- rstcnt increments by 1 each clock after reset release and saturates at 4 (3'b100). pc_o holds RSTPC until rstcnt[2]=1.
- States: RESET, RUN, MISS, REDIR.
- RESET -> RUN when rstcnt reaches 4.
- RUN, priority order:
  - branch_miss: pc_o.pc<=misspc.pc; bno_t<=next(bno_t); bno_f<=old bno_t; stomp_fet<=1 for one cycle; stomp_bno<=next(bno_t); go REDIR.
  - else bp_taken && en: pc_o.pc<=bp_tgt.pc; bno_t<=next(bno_t); stomp_fet<=1 for one cycle; stomp_bno<=next(bno_t).
  - else en && !ihit: hold pc_o; go MISS; clear miss counter.
  - else en && ihit: pc_o.pc<=pc_o.pc+FETCH_INC, modulo address width with no carry out.
  - else (!en): hold all.
- MISS: pc_o held. Counter increments each cycle, saturating.
  - ihit -> RUN, with no increment in that cycle.
  - Counter == MISS_TMO -> miss_tmo<=1 (sticky until reset); stay in MISS.
  - branch_miss overrides: same actions as in RUN, go REDIR.
- REDIR: one bubble cycle, pc_o held; -> RUN.
  - A second branch_miss here re-applies the redirect and stays in REDIR.
- next(b): b+1, except BNO_W'(2^BNO_W-1) -> 1. Value 0 is reserved/invalid and never produced.
- en low during branch_miss: the redirect still applies immediately. branch_miss is never lost.
- en low during bp_taken: bp_taken is latched in the pending register, applied on the first cycle with en=1 and no branch_miss, then cleared. A branch_miss clears the pending register.
- Simultaneous branch_miss and bp_taken: branch_miss wins; bp_taken is dropped.
- During RESET, branch_miss and bp_taken are ignored.
- Reset asserted mid-operation returns everything to reset values asynchronously.
- Latency: redirect visible on pc_o the cycle after the input pulse. stomp_fet is asserted in that same cycle.

Decomposition:
- Stark_pkg: pc_address_ex_t, RSTPC, and a fetch_pcgen_state_t enum {RESET,RUN,MISS,REDIR}.
- cpu_types_pkg: address width.
- One natural sub-module: stark_bno_inc (combinational next-branch-number with zero skip), reused by the rename/branch logic.

Test Plan:
- Release reset -> rstcnt 0,1,2,3,4 on successive clocks. pc_o.pc=RSTPC throughout. Then with en=1 and ihit=1: pc_o.pc = RSTPC+20, RSTPC+40.
- ihit=0 for 3 cycles in RUN -> pc_o holds for 3 cycles. ihit=1 -> next cycle pc_o advances by 20.
- Hold ihit=0 for 256 cycles -> miss_tmo=1 after MISS_TMO cycles, stays 1. Then ihit=1 -> RUN; miss_tmo remains 1 until reset.
- bno_t=5, branch_miss with misspc.pc=0x1000 -> next cycle: pc_o.pc=0x1000, bno_t=6, bno_f=5, stomp_fet=1, stomp_bno=6. Following cycle: stomp_fet=0, pc_o held (REDIR).
- branch_miss and bp_taken in the same cycle -> pc_o.pc=misspc.pc. bp_tgt never appears.
- bno_t=63, bp_taken with en=0 -> pending; no change. When en=1: pc_o.pc=bp_tgt.pc, bno_t=1 (zero skipped).

Source files
------------

// File: rtl/stark_fetch_pcgen_pkg.sv
// Shared types for the fetch PC generator: address width, extended PC, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stark_fetch_pcgen_pkg;

  localparam int AWID    = 32;
  localparam int BNO_WID = 6;

  typedef logic [AWID-1:0]    address_t;
  typedef logic [BNO_WID-1:0] branch_num_t;

  // Fetch PC tagged with the taken/fall-through branch numbers it belongs to.
  typedef struct packed {
    branch_num_t bno_t;
    branch_num_t bno_f;
    address_t    pc;
  } pc_address_ex_t;

  localparam address_t RSTPC = 32'hFFFC_0100;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    REDIR = 2'd3
  } fetch_pcgen_state_t;

endpackage

// File: rtl/stark_bno_inc.sv
// Next branch number: b+1, wrapping from all-ones back to 1 so 0 is never produced.
// Latency: combinational.
// Backpressure: none.
module stark_bno_inc #(
  parameter int W = 6
) (
  input  logic [W-1:0] bno,
  output logic [W-1:0] bno_nxt
);

  // Increment with the reserved zero value skipped on wrap.
  always_comb begin
    bno_nxt = bno + W'(1);
    if (bno == {W{1'b1}}) begin
      bno_nxt = W'(1);
    end
  end

endmodule

// File: rtl/stark_fetch_pcgen.sv
// Fetch PC generator: sequential fetch, icache-miss hold, predicted redirects, mispredict recovery.
// Latency: redirects and stomps appear on pc_o/stomp_fet the cycle after the input pulse.
// Backpressure: en low holds the PC; a bp_taken seen while stalled is parked until en returns.
module stark_fetch_pcgen
  import stark_fetch_pcgen_pkg::*;
#(
  parameter int unsigned FETCH_INC = 20,
  parameter int          BNO_W     = BNO_WID,
  parameter int unsigned MISS_TMO  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ihit,
  input  logic             branch_miss,
  input  pc_address_ex_t   misspc,
  input  logic             bp_taken,
  input  pc_address_ex_t   bp_tgt,
  output pc_address_ex_t   pc_o,
  output logic [2:0]       rstcnt,
  output logic             stomp_fet,
  output logic [BNO_W-1:0] stomp_bno,
  output logic             miss_tmo
);

  localparam int MCW = $clog2(MISS_TMO + 1);

  fetch_pcgen_state_t state, state_d;
  pc_address_ex_t     pc_r, pc_d;
  logic [2:0]         rstcnt_d;
  logic               stomp_d;
  logic [BNO_W-1:0]   sbno_d;
  logic               tmo_d;
  logic [MCW-1:0]     miss_cnt, miss_cnt_d;
  logic               pend_vld, pend_vld_d;
  address_t           pend_pc, pend_pc_d;
  address_t           redir_pc;
  branch_num_t        bno_nxt;

  // Only the pc field of the redirect targets is meaningful here.
  logic unused_bno_fields;
  assign unused_bno_fields = ^{misspc.bno_t, misspc.bno_f, bp_tgt.bno_t, bp_tgt.bno_f};

  stark_bno_inc #(.W(BNO_WID)) u_bno_inc (
    .bno     (pc_r.bno_t),
    .bno_nxt (bno_nxt)
  );

  assign pc_o = pc_r;

  // State register and all output/holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RESET;
      pc_r      <= '{bno_t: BNO_WID'(1), bno_f: BNO_WID'(1), pc: RSTPC};
      rstcnt    <= 3'd0;
      stomp_fet <= 1'b0;
      stomp_bno <= '0;
      miss_tmo  <= 1'b0;
      miss_cnt  <= '0;
      pend_vld  <= 1'b0;
      pend_pc   <= '0;
    end else begin
      state     <= state_d;
      pc_r      <= pc_d;
      rstcnt    <= rstcnt_d;
      stomp_fet <= stomp_d;
      stomp_bno <= sbno_d;
      miss_tmo  <= tmo_d;
      miss_cnt  <= miss_cnt_d;
      pend_vld  <= pend_vld_d;
      pend_pc   <= pend_pc_d;
    end
  end

  // Next-state and next-PC selection; mispredicts outrank everything outside RESET.
  always_comb begin
    state_d    = state;
    pc_d       = pc_r;
    stomp_d    = 1'b0;
    sbno_d     = stomp_bno;
    tmo_d      = miss_tmo;
    miss_cnt_d = miss_cnt;
    pend_vld_d = pend_vld;
    pend_pc_d  = pend_pc;
    rstcnt_d   = rstcnt[2] ? rstcnt : rstcnt + 3'd1;
    redir_pc   = bp_taken ? bp_tgt.pc : pend_pc;

    if (state == RESET) begin
      // Leave reset on the same edge that the settle counter reaches 4.
      if (rstcnt_d[2]) begin
        state_d = RUN;
      end
    end else if (branch_miss) begin
      pc_d.pc    = misspc.pc;
      pc_d.bno_t = bno_nxt;
      pc_d.bno_f = pc_r.bno_t;
      stomp_d    = 1'b1;
      sbno_d     = BNO_W'(bno_nxt);
      pend_vld_d = 1'b0;
      state_d    = REDIR;
    end else begin
      // A prediction that cannot be taken right now is parked for later.
      if (bp_taken && !(state == RUN && en)) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = bp_tgt.pc;
      end
      case (state)
        RUN: begin
          if (en && (bp_taken || pend_vld)) begin
            pc_d.pc    = redir_pc;
            pc_d.bno_t = bno_nxt;
            stomp_d    = 1'b1;
            sbno_d     = BNO_W'(bno_nxt);
            pend_vld_d = 1'b0;
          end else if (en && !ihit) begin
            miss_cnt_d = '0;
            state_d    = MISS;
          end else if (en) begin
            pc_d.pc = pc_r.pc + AWID'(FETCH_INC);
          end
        end
        MISS: begin
          if (ihit) begin
            state_d = RUN;
          end else begin
            if (miss_cnt == MCW'(MISS_TMO)) begin
              tmo_d = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt + MCW'(1);
            end
          end
        end
        default: begin
          // REDIR: single bubble after a mispredict.
          state_d = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stark_fetch_pcgen.sv
module tb_stark_fetch_pcgen;
  import stark_fetch_pcgen_pkg::*;

  logic           clk;
  logic           rst;
  logic           en;
  logic           ihit;
  logic           branch_miss;
  pc_address_ex_t misspc;
  logic           bp_taken;
  pc_address_ex_t bp_tgt;
  pc_address_ex_t pc_o;
  logic [2:0]     rstcnt;
  logic           stomp_fet;
  logic [5:0]     stomp_bno;
  logic           miss_tmo;

  int n_chk  = 0;
  int n_fail = 0;

  stark_fetch_pcgen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ihit        (ihit),
    .branch_miss (branch_miss),
    .misspc      (misspc),
    .bp_taken    (bp_taken),
    .bp_tgt      (bp_tgt),
    .pc_o        (pc_o),
    .rstcnt      (rstcnt),
    .stomp_fet   (stomp_fet),
    .stomp_bno   (stomp_bno),
    .miss_tmo    (miss_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch-number successor computed arithmetically: 1..62 -> +1, 63 -> 1.
  function automatic logic [5:0] nb(input logic [5:0] b);
    return 6'((int'(b) % 63) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; ihit = 1'b0; branch_miss = 1'b0; bp_taken = 1'b0;
    misspc = '0; bp_tgt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #13;
    rst = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    n_chk++;
    if (pc_o !== '{bno_t: 6'd1, bno_f: 6'd1, pc: RSTPC}) begin
      n_fail++; $display("FAIL reset_pc got %h want pc=%h bno=1/1", pc_o, RSTPC);
    end
    n_chk++;
    if ({rstcnt, stomp_fet, stomp_bno, miss_tmo} !== 11'd0) begin
      n_fail++; $display("FAIL reset_outs got rstcnt=%0d stomp=%b sbno=%0d tmo=%b want all 0", rstcnt, stomp_fet, stomp_bno, miss_tmo);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_chk++;
      if (rstcnt !== 3'(i > 4 ? 4 : i) || pc_o.pc !== RSTPC) begin
        n_fail++; $display("FAIL settle_%0d got rstcnt=%0d pc=%h want rstcnt=%0d pc=%h", i, rstcnt, pc_o.pc, (i > 4 ? 4 : i), RSTPC);
      end
    end
  endtask

  task automatic test_seq_advance();
    en = 1'b1; ihit = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_chk++;
      if (pc_o.pc !== RSTPC + 32'(20 * i)) begin
        n_fail++; $display("FAIL seq_adv_%0d got %h want %h", i, pc_o.pc, RSTPC + 32'(20 * i));
      end
    end
  endtask

  task automatic test_miss_hold();
    logic [31:0] held;
    held = pc_o.pc;
    en = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (pc_o.pc !== held) begin
        n_fail++; $display("FAIL miss_hold_%0d got %h want %h", i, pc_o.pc, held);
      end
    end
    ihit = 1'b1;
    tick();
    n_chk++;
    if (pc_o.pc !== held) begin
      n_fail++; $display("FAIL miss_exit got %h want %h", pc_o.pc, held);
    end
    tick();
    n_chk++;
    if (pc_o.pc !== held + 32'd20) begin
      n_fail++; $display("FAIL miss_resume got %h want %h", pc_o.pc, held + 32'd20);
    end
  endtask

  task automatic test_branch_miss();
    do_reset();
    en = 1'b1; ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bp_taken = 1'b1; bp_tgt.pc = 32'h0000_0800 + 32'(i * 64);
      tick();
    end
    bp_taken = 1'b0;
    n_chk++;
    if (pc_o.bno_t !== 6'd5) begin
      n_fail++; $display("FAIL bm_setup got bno_t=%0d want 5", pc_o.bno_t);
    end
    branch_miss = 1'b1; misspc.pc = 32'h0000_1000;
    tick();
    branch_miss = 1'b0;
    n_chk++;
    if (pc_o !== '{bno_t: 6'd6, bno_f: 6'd5, pc: 32'h1000} || stomp_fet !== 1'b1 || stomp_bno !== 6'd6) begin
      n_fail++; $display("FAIL bm_redirect got pc=%h t=%0d f=%0d stomp=%b sbno=%0d want 1000 6 5 1 6", pc_o.pc, pc_o.bno_t, pc_o.bno_f, stomp_fet, stomp_bno);
    end
    tick();
    n_chk++;
    if (stomp_fet !== 1'b0 || pc_o.pc !== 32'h1000) begin
      n_fail++; $display("FAIL bm_bubble got stomp=%b pc=%h want 0 1000", stomp_fet, pc_o.pc);
    end
    tick();
    n_chk++;
    if (pc_o.pc !== 32'h1014) begin
      n_fail++; $display("FAIL bm_resume got %h want 1014", pc_o.pc);
    end
  endtask

  task automatic test_simul();
    en = 1'b1; ihit = 1'b1;
    branch_miss = 1'b1; misspc.pc = 32'h0000_2000;
    bp_taken = 1'b1; bp_tgt.pc = 32'h0000_3000;
    tick();
    branch_miss = 1'b0; bp_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (pc_o.pc !== (i < 2 ? 32'h2000 : 32'h2014)) begin
        n_fail++; $display("FAIL simul_%0d got %h want %h", i, pc_o.pc, (i < 2 ? 32'h2000 : 32'h2014));
      end
      tick();
    end
  endtask

  task automatic test_pending_wrap();
    int guard;
    logic [31:0] held;
    en = 1'b1; ihit = 1'b1;
    guard = 0;
    while (pc_o.bno_t !== 6'd63 && guard < 80) begin
      bp_taken = 1'b1; bp_tgt.pc = 32'h0001_0000 + 32'(guard * 4);
      tick();
      guard++;
    end
    bp_taken = 1'b0;
    n_chk++;
    if (pc_o.bno_t !== 6'd63) begin
      n_fail++; $display("FAIL pend_setup got bno_t=%0d want 63", pc_o.bno_t);
    end
    held = pc_o.pc;
    en = 1'b0; bp_taken = 1'b1; bp_tgt.pc = 32'h0000_4000;
    tick();
    bp_taken = 1'b0; bp_tgt.pc = 32'h0000_5000;
    n_chk++;
    if (pc_o.pc !== held || pc_o.bno_t !== 6'd63 || stomp_fet !== 1'b0) begin
      n_fail++; $display("FAIL pend_hold got pc=%h t=%0d stomp=%b want %h 63 0", pc_o.pc, pc_o.bno_t, stomp_fet, held);
    end
    en = 1'b1;
    tick();
    n_chk++;
    if (pc_o.pc !== 32'h4000 || pc_o.bno_t !== 6'd1 || stomp_fet !== 1'b1 || stomp_bno !== 6'd1) begin
      n_fail++; $display("FAIL pend_apply got pc=%h t=%0d stomp=%b sbno=%0d want 4000 1 1 1", pc_o.pc, pc_o.bno_t, stomp_fet, stomp_bno);
    end
  endtask

  task automatic test_random();
    pc_address_ex_t m_pc;
    logic           m_stomp;
    logic [5:0]     m_sbno;
    bit             m_miss, m_bub, m_pend, m_tmo;
    logic [31:0]    m_ppc;
    int             m_cnt;
    do_reset();
    m_pc = '{bno_t: 6'd1, bno_f: 6'd1, pc: RSTPC};
    m_stomp = 1'b0; m_sbno = 6'd0; m_miss = 0; m_bub = 0; m_pend = 0; m_tmo = 0;
    m_ppc = '0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      ihit        = ($urandom_range(0, 3) != 0);
      branch_miss = ($urandom_range(0, 15) == 0);
      bp_taken    = ($urandom_range(0, 7) == 0);
      misspc      = {6'($urandom), 6'($urandom), 32'($urandom)};
      bp_tgt      = {6'($urandom), 6'($urandom), 32'($urandom)};
      tick();
      m_stomp = 1'b0;
      if (branch_miss) begin
        m_pc.bno_f = m_pc.bno_t;
        m_pc.bno_t = nb(m_pc.bno_t);
        m_pc.pc    = misspc.pc;
        m_stomp = 1'b1; m_sbno = m_pc.bno_t;
        m_pend = 0; m_miss = 0; m_bub = 1;
      end else if (m_bub || m_miss) begin
        if (bp_taken) begin m_pend = 1; m_ppc = bp_tgt.pc; end
        if (m_bub) m_bub = 0;
        else if (ihit) m_miss = 0;
        else begin
          if (m_cnt == 255) m_tmo = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end else if (en && (bp_taken || m_pend)) begin
        m_pc.pc    = bp_taken ? bp_tgt.pc : m_ppc;
        m_pc.bno_t = nb(m_pc.bno_t);
        m_stomp = 1'b1; m_sbno = m_pc.bno_t; m_pend = 0;
      end else begin
        if (bp_taken) begin m_pend = 1; m_ppc = bp_tgt.pc; end
        if (en && !ihit) begin m_miss = 1; m_cnt = 0; end
        else if (en) m_pc.pc = m_pc.pc + 32'd20;
      end
      n_chk++;
      if (pc_o !== m_pc || stomp_fet !== m_stomp || stomp_bno !== m_sbno || miss_tmo !== m_tmo || rstcnt !== 3'd4) begin
        n_fail++;
        $display("FAIL rand_%0d got pc=%h t=%0d f=%0d st=%b sb=%0d tmo=%b want pc=%h t=%0d f=%0d st=%b sb=%0d tmo=%b",
                 i, pc_o.pc, pc_o.bno_t, pc_o.bno_f, stomp_fet, stomp_bno, miss_tmo,
                 m_pc.pc, m_pc.bno_t, m_pc.bno_f, m_stomp, m_sbno, m_tmo);
      end
    end
  endtask

  task automatic test_miss_timeout();
    logic [31:0] held;
    do_reset();
    en = 1'b1; ihit = 1'b0;
    held = pc_o.pc;
    repeat (100) tick();
    n_chk++;
    if (miss_tmo !== 1'b0 || pc_o.pc !== held) begin
      n_fail++; $display("FAIL tmo_early got tmo=%b pc=%h want 0 %h", miss_tmo, pc_o.pc, held);
    end
    repeat (200) tick();
    n_chk++;
    if (miss_tmo !== 1'b1 || pc_o.pc !== held) begin
      n_fail++; $display("FAIL tmo_set got tmo=%b pc=%h want 1 %h", miss_tmo, pc_o.pc, held);
    end
    ihit = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (miss_tmo !== 1'b1 || pc_o.pc !== held + 32'd20) begin
      n_fail++; $display("FAIL tmo_sticky got tmo=%b pc=%h want 1 %h", miss_tmo, pc_o.pc, held + 32'd20);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; ihit = 1'b1;
    branch_miss = 1'b1; misspc.pc = 32'h0000_6000;
    tick();
    branch_miss = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    n_chk++;
    if (pc_o !== '{bno_t: 6'd1, bno_f: 6'd1, pc: RSTPC} || {rstcnt, stomp_fet, stomp_bno, miss_tmo} !== 11'd0) begin
      n_fail++; $display("FAIL async_rst got pc=%h t=%0d f=%0d rstcnt=%0d st=%b sb=%0d tmo=%b want reset values",
                         pc_o.pc, pc_o.bno_t, pc_o.bno_f, rstcnt, stomp_fet, stomp_bno, miss_tmo);
    end
    #20;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_seq_advance();
    test_miss_hold();
    test_branch_miss();
    test_simul();
    test_pending_wrap();
    test_random();
    test_miss_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
